// File: rtl/alu16_seq_pkg.sv
// Shared encodings for the 16-bit ADD/ADC/SBC sequencer: op codes, FSM states,
// F-register bit positions and the 8-bit ALU function codes.
package alu16_seq_pkg;

   localparam logic [2:0] OP_ADD16 = 3'd0;
   localparam logic [2:0] OP_ADC16 = 3'd1;
   localparam logic [2:0] OP_SBC16 = 3'd2;
   localparam logic [2:0] OP_INC16 = 3'd3;
   localparam logic [2:0] OP_DEC16 = 3'd4;

   typedef enum logic [1:0] {IDLE, LO, HI} state_t;

   localparam int FLAG_S = 7;
   localparam int FLAG_Z = 6;
   localparam int FLAG_H = 4;
   localparam int FLAG_V = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 0;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_ADC = 2'd1;
   localparam logic [1:0] ALU_SUB = 2'd2;
   localparam logic [1:0] ALU_SBC = 2'd3;

endpackage

// File: rtl/alu16_sequencer_alu8.sv
// 8-bit ALU slice. co/hco are raw adder carry-outs of bit 7 / bit 3; for SUB/SBC
// they read 1 = no borrow. cin for SBC is a borrow (Z80 style).
module alu16_sequencer_alu8
   import alu16_seq_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [1:0] func,
   input  logic       cin,
   output logic [7:0] res,
   output logic       co,
   output logic       hco,
   output logic       v,
   output logic       z
);

   logic       sub;
   logic       ci;
   logic [7:0] bb;
   logic [8:0] sum9;
   logic [4:0] half;

   always_comb begin
      sub = func[1];
      bb  = sub ? ~b : b;
      case (func)
         ALU_ADD: ci = 1'b0;
         ALU_ADC: ci = cin;
         ALU_SUB: ci = 1'b1;
         default: ci = ~cin;
      endcase
      sum9 = {1'b0, a} + {1'b0, bb} + {8'b0, ci};
      half = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'b0, ci};
      res  = sum9[7:0];
      co   = sum9[8];
      hco  = half[4];
      v    = (a[7] == bb[7]) && (sum9[7] != a[7]);
      z    = (sum9[7:0] == 8'h00);
   end

endmodule

// File: rtl/alu16_sequencer.sv
// Z80 16-bit ADD/ADC/SBC on one shared 8-bit ALU: low byte then high byte.
// Define ALU16_INCDEC_EN to add INC16/DEC16 (ops 3/4); otherwise they are illegal.
module alu16_sequencer
   import alu16_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [7:0]  f_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic [7:0]  f_out,
   output logic        illegal
);

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [15:0] x_q, x_d, y_q, y_d, result_q, result_d;
   logic [7:0]  f_q, f_d, lo_out_q, lo_out_d, f_out_q, f_out_d;
   logic        lo_cout_q, lo_cout_d, lo_z_q, lo_z_d;
   logic        done_q, done_d, illegal_q, illegal_d;

   logic        is_add, is_adc, is_sbc, is_inc, is_dec, is_sub, legal;
   logic [15:0] y_eff;
   logic [7:0]  alu_a, alu_b, alu_res;
   logic [1:0]  alu_func;
   logic        alu_cin, alu_co, alu_hco, alu_v, alu_z;
   logic        hi_h, hi_c;
   logic [7:0]  f_arith;

   alu16_sequencer_alu8 u_alu8 (
      .a(alu_a), .b(alu_b), .func(alu_func), .cin(alu_cin),
      .res(alu_res), .co(alu_co), .hco(alu_hco), .v(alu_v), .z(alu_z)
   );

   always_comb begin
      is_add = (op_q == OP_ADD16);
      is_adc = (op_q == OP_ADC16);
      is_sbc = (op_q == OP_SBC16);
`ifdef ALU16_INCDEC_EN
      is_inc = (op_q == OP_INC16);
      is_dec = (op_q == OP_DEC16);
`else
      is_inc = 1'b0;
      is_dec = 1'b0;
`endif
      is_sub = is_sbc | is_dec;
      legal  = is_add | is_adc | is_sbc | is_inc | is_dec;
      y_eff  = (is_inc | is_dec) ? 16'h0001 : y_q;

      // One ALU serves both bytes; state picks the byte, the function and the carry source.
      if (state_q == HI) begin
         alu_a    = x_q[15:8];
         alu_b    = y_eff[15:8];
         alu_func = is_sub ? ALU_SBC : ALU_ADC;
         alu_cin  = is_sub ? ~lo_cout_q : lo_cout_q;
      end else begin
         alu_a    = x_q[7:0];
         alu_b    = y_eff[7:0];
         alu_cin  = f_q[FLAG_C];
         if (is_adc)      alu_func = ALU_ADC;
         else if (is_sbc) alu_func = ALU_SBC;
         else if (is_dec) alu_func = ALU_SUB;
         else             alu_func = ALU_ADD;
      end

      hi_h    = is_sub ? ~alu_hco : alu_hco;
      hi_c    = is_sub ? ~alu_co  : alu_co;
      f_arith = 8'h00;
      f_arith[FLAG_H] = hi_h;
      f_arith[FLAG_C] = hi_c;
      if (is_add) begin
         f_arith[FLAG_S] = f_q[FLAG_S];
         f_arith[FLAG_Z] = f_q[FLAG_Z];
         f_arith[FLAG_V] = f_q[FLAG_V];
      end else begin
         f_arith[FLAG_S] = alu_res[7];
         f_arith[FLAG_Z] = lo_z_q & alu_z;
         f_arith[FLAG_V] = alu_v;
         f_arith[FLAG_N] = is_sbc;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      x_d       = x_q;
      y_d       = y_q;
      f_d       = f_q;
      lo_out_d  = lo_out_q;
      lo_cout_d = lo_cout_q;
      lo_z_d    = lo_z_q;
      result_d  = result_q;
      f_out_d   = f_out_q;
      illegal_d = illegal_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = LO;
            op_d    = op;
            x_d     = x;
            y_d     = y;
            f_d     = f_in;
         end
         LO: begin
            state_d   = HI;
            lo_out_d  = alu_res;
            lo_cout_d = alu_co;
            lo_z_d    = alu_z;
         end
         HI: begin
            state_d   = IDLE;
            done_d    = 1'b1;
            illegal_d = ~legal;
            if (!legal) begin
               result_d = x_q;
               f_out_d  = f_q;
            end else begin
               result_d = {alu_res, lo_out_q};
               f_out_d  = (is_inc | is_dec) ? f_q : f_arith;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         op_q      <= 3'd0;
         x_q       <= 16'h0;
         y_q       <= 16'h0;
         f_q       <= 8'h0;
         lo_out_q  <= 8'h0;
         lo_cout_q <= 1'b0;
         lo_z_q    <= 1'b0;
         result_q  <= 16'h0;
         f_out_q   <= 8'h0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         x_q       <= x_d;
         y_q       <= y_d;
         f_q       <= f_d;
         lo_out_q  <= lo_out_d;
         lo_cout_q <= lo_cout_d;
         lo_z_q    <= lo_z_d;
         result_q  <= result_d;
         f_out_q   <= f_out_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign result  = result_q;
   assign f_out   = f_out_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_alu16_sequencer.sv
// Randomized bench for alu16_sequencer against a 16-bit arithmetic reference model.
module tb_alu16_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [15:0] x = 16'h0, y = 16'h0;
   logic [7:0]  f_in = 8'h0;
   logic        busy, done, illegal;
   logic [15:0] result;
   logic [7:0]  f_out;

   int errors = 0;
   int checks = 0;

   alu16_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .x(x), .y(y), .f_in(f_in),
      .busy(busy), .done(done), .result(result), .f_out(f_out), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns {illegal, result[15:0], f[7:0]} from plain 16-bit arithmetic.
   function automatic logic [24:0] model(input logic [2:0] o, input logic [15:0] a,
                                         input logic [15:0] b, input logic [7:0] f);
      int ai, bi, ci, r, sa, sb, s, h;
      logic [15:0] res;
      logic [7:0]  fo;
      ai = a; bi = b; ci = f[0];
      sa = a[15] ? ai - 65536 : ai;
      sb = b[15] ? bi - 65536 : bi;
      fo = 8'h00;
      case (o)
         3'd0: begin
            r = ai + bi; res = r[15:0];
            h = (ai & 'hfff) + (bi & 'hfff);
            fo = {f[7], f[6], 1'b0, h > 'hfff, 1'b0, f[2], 1'b0, r > 'hffff};
            return {1'b0, res, fo};
         end
         3'd1: begin
            r = ai + bi + ci; res = r[15:0];
            h = (ai & 'hfff) + (bi & 'hfff) + ci;
            s = sa + sb + ci;
            fo = {res[15], res == 16'h0, 1'b0, h > 'hfff, 1'b0, (s > 32767) || (s < -32768), 1'b0, r > 'hffff};
            return {1'b0, res, fo};
         end
         3'd2: begin
            r = ai - bi - ci; res = r[15:0];
            h = (ai & 'hfff) - (bi & 'hfff) - ci;
            s = sa - sb - ci;
            fo = {res[15], res == 16'h0, 1'b0, h < 0, 1'b0, (s > 32767) || (s < -32768), 1'b1, r < 0};
            return {1'b0, res, fo};
         end
`ifdef ALU16_INCDEC_EN
         3'd3: begin r = ai + 1; res = r[15:0]; return {1'b0, res, f}; end
         3'd4: begin r = ai - 1; res = r[15:0]; return {1'b0, res, f}; end
`endif
         default: return {1'b1, a, f};
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] f);
      logic [24:0] m;
      m = model(o, a, b, f);
      @(negedge clk);
      start = 1'b1; op = o; x = a; y = b; f_in = f;
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); x = 16'($urandom); y = 16'($urandom); f_in = 8'($urandom);
      chk({tag, ".busy_lo"}, busy, 1);
      chk({tag, ".done_lo"}, done, 0);
      @(posedge clk); #1;
      chk({tag, ".busy_hi"}, busy, 1);
      @(posedge clk); #1;
      chk({tag, ".done"}, done, 1);
      chk({tag, ".busy_end"}, busy, 0);
      chk({tag, ".result"}, result, m[23:8]);
      chk({tag, ".f_out"}, f_out, m[7:0]);
      chk({tag, ".illegal"}, illegal, m[24]);
   endtask

   initial begin
      int cnt;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.result", result, 0);
      chk("rst.f_out", f_out, 0);
      chk("rst.illegal", illegal, 0);
      @(negedge clk); reset = 1'b0;

      run_op("add_hc", 3'd0, 16'h0FFF, 16'h0001, 8'hC4);
      chk("add_hc.lit", {result, f_out}, {16'h1000, 8'hD4});
      run_op("adc_ov", 3'd1, 16'h7FFF, 16'h0000, 8'h01);
      chk("adc_ov.lit", {result, f_out}, {16'h8000, 8'h94});
      run_op("sbc_bw", 3'd2, 16'h0000, 16'h0001, 8'h00);
      chk("sbc_bw.lit", {result, f_out}, {16'hFFFF, 8'h93});
      run_op("sbc_z", 3'd2, 16'h1234, 16'h1233, 8'h01);
      chk("sbc_z.lit", {result, f_out}, {16'h0000, 8'h42});
      run_op("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 8'h00);
      run_op("ill5", 3'd5, 16'hBEEF, 16'h1111, 8'hD7);
      run_op("after_ill", 3'd1, 16'h8000, 16'h8000, 8'h00);
      run_op("op3", 3'd3, 16'hFFFF, 16'h5555, 8'h95);
      run_op("op4", 3'd4, 16'h0000, 16'h5555, 8'h42);

      for (int i = 0; i < 60; i++)
         run_op("rnd", 3'($urandom_range(0, 6)), 16'($urandom), 16'($urandom),
                8'($urandom) & 8'hD7);

      // reset while in LO aborts silently and clears outputs
      @(negedge clk);
      start = 1'b1; op = 3'd0; x = 16'h1234; y = 16'h1111; f_in = 8'h00;
      @(posedge clk); #1;
      start = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rstlo.busy", busy, 0);
      chk("rstlo.result", result, 0);
      chk("rstlo.f_out", f_out, 0);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (done) cnt++;
      end
      chk("rstlo.no_done", cnt, 0);

      // start held high: one completion every third cycle
      @(negedge clk);
      start = 1'b1; op = 3'd1; x = 16'h0101; y = 16'h0202; f_in = 8'h00;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         chk("b2b.done", done, (i % 3) == 2);
      end
      @(negedge clk); start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("b2b.idle", busy, 0);

      // start pulse while busy is dropped
      @(negedge clk);
      start = 1'b1; op = 3'd0; x = 16'h0010; y = 16'h0020; f_in = 8'h00;
      @(posedge clk); #1;
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      cnt = 0;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         if (done) cnt++;
      end
      chk("busy_start.dones", cnt, 1);
      chk("busy_start.result", result, 16'h0030);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
